// File: rtl/core_ldst_misc_pkg.sv
// Shared load/store micro-architecture types: access size, register number
// and the misc load/store sequencer state encoding.
package core_ldst_misc_pkg;

    typedef enum logic [1:0] {
        LDST_BYTE = 2'd0,
        LDST_HALF = 2'd1,
        LDST_WORD = 2'd2,
        LDST_DUAL = 2'd3
    } ldst_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_FIN  = 2'd3
    } ldst_state_e;

    typedef logic [3:0] reg_num_t;

endpackage

// File: rtl/core_ldst_misc_lanes.sv
// Byte-lane steering for one bus access: byte enables, store replication,
// load lane extraction and zero/sign extension. Purely combinational.
module core_ldst_misc_lanes
    import core_ldst_misc_pkg::*;
(
    input  ldst_size_e  acc_size_i,
    input  ldst_size_e  op_size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sext_i,
    input  logic        merge_i,
    input  logic [7:0]  lo_byte_i,
    input  logic [31:0] st_word_i,
    input  logic [31:0] rd_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [7:0]  lane_byte_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;
    logic [15:0] half_val;

    // Enables and store data follow the size of this particular access
    always_comb begin
        be_o      = 4'hF;
        st_data_o = st_word_i;
        case (acc_size_i)
            LDST_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                st_data_o = {4{st_word_i[7:0]}};
            end
            LDST_HALF: begin
                be_o      = 4'b0011 << addr_lo_i;
                st_data_o = {2{st_word_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction; a split halfword merges the earlier low byte with this lane
    always_comb begin
        shifted     = rd_data_i >> {addr_lo_i, 3'b000};
        lane_byte_o = shifted[7:0];
        half_val    = merge_i ? {shifted[7:0], lo_byte_i}
                              : (addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0]);
        case (op_size_i)
            LDST_BYTE: ld_data_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            LDST_HALF: ld_data_o = {{16{sext_i & half_val[15]}}, half_val};
            default:   ld_data_o = rd_data_i;
        endcase
    end

endmodule

// File: rtl/core_ldst_misc_fsm.sv
// Misc load/store sequencer (byte, halfword, signed, dual-word transfers).
// Optional build macro CORE_LDST_MISC_UNALIGNED_EN: odd-address halfwords are
// split into two byte accesses instead of faulting.
//
// state | meaning
// IDLE  | ready, waiting for start
// ACC0  | first (or only) bus access in flight
// ACC1  | second access: upper word of a dual, or high byte of a split half
// FIN   | report done/fault/writeback, then return to IDLE
module core_ldst_misc_fsm
    import core_ldst_misc_pkg::*;
#(
    parameter int OFF_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             load_i,
    input  ldst_size_e       size_i,
    input  logic             sign_extend_i,
    input  logic             increment_i,
    input  logic             pre_indexed_i,
    input  logic             writeback_i,
    input  reg_num_t         rd_i,
    input  logic [31:0]      base_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [63:0]      store_data_i,
    output logic             bus_start_o,
    output logic             bus_write_o,
    output logic [29:0]      bus_addr_o,
    output logic [3:0]       bus_be_o,
    output logic [31:0]      bus_data_wr_o,
    input  logic             bus_ready_i,
    input  logic [31:0]      bus_data_rd_i,
    output logic             ld_wr_o,
    output reg_num_t         ld_rd_o,
    output logic [31:0]      ld_data_o,
    output logic             wb_en_o,
    output logic [31:0]      wb_addr_o,
    output logic             done_o,
    output logic             fault_o
);

`ifdef CORE_LDST_MISC_UNALIGNED_EN
    localparam bit UNALIGNED_EN = 1'b1;
`else
    localparam bit UNALIGNED_EN = 1'b0;
`endif

    ldst_state_e state_q, state_d;
    logic        accept, acc_done, need_two, in_acc, merge;
    logic [31:0] off_ext, off_addr, eff;
    logic        split_req, fault_req;

    logic        load_q, sext_q, wb_q, split_q, fault_q;
    ldst_size_e  size_q, acc_size;
    reg_num_t    rd_q, ld_rd_q;
    logic [63:0] sd_q;
    logic [31:0] eff_q, off_q, acc_addr_q, ld_data_q, wb_addr_q, st_word;
    logic [7:0]  lo_byte_q;
    logic        bus_start_q, ld_wr_q, done_q, fault_out_q, wb_en_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_st, lane_ld;
    logic [7:0]  lane_byte;

    // Address arithmetic and alignment screening on the incoming request
    always_comb begin
        off_ext   = 32'(offset_i);
        off_addr  = increment_i ? base_i + off_ext : base_i - off_ext;
        eff       = pre_indexed_i ? off_addr : base_i;
        split_req = UNALIGNED_EN && (size_i == LDST_HALF) && eff[0];
        fault_req = 1'b0;
        case (size_i)
            LDST_HALF: fault_req = eff[0] && !UNALIGNED_EN;
            LDST_WORD: fault_req = (eff[1:0] != 2'b00);
            LDST_DUAL: fault_req = (eff[1:0] != 2'b00) || rd_i[0];
            default:   ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; bus_ready only matters while an access is in flight
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        acc_done = 1'b0;
        need_two = (size_q == LDST_DUAL) || split_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                accept  = 1'b1;
                state_d = fault_req ? ST_FIN : ST_ACC0;
            end
            ST_ACC0: if (bus_ready_i) begin
                acc_done = 1'b1;
                state_d  = need_two ? ST_ACC1 : ST_FIN;
            end
            ST_ACC1: if (bus_ready_i) begin
                acc_done = 1'b1;
                state_d  = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-access lane controls derived from the latched request
    always_comb begin
        in_acc   = (state_q == ST_ACC0) || (state_q == ST_ACC1);
        merge    = split_q && (state_q == ST_ACC1);
        acc_size = split_q ? LDST_BYTE : size_q;
        if (state_q == ST_ACC1) st_word = split_q ? {24'h0, sd_q[15:8]} : sd_q[63:32];
        else                    st_word = sd_q[31:0];
    end

    core_ldst_misc_lanes u_lanes (
        .acc_size_i  (acc_size),
        .op_size_i   (size_q),
        .addr_lo_i   (acc_addr_q[1:0]),
        .sext_i      (sext_q),
        .merge_i     (merge),
        .lo_byte_i   (lo_byte_q),
        .st_word_i   (st_word),
        .rd_data_i   (bus_data_rd_i),
        .be_o        (lane_be),
        .st_data_o   (lane_st),
        .lane_byte_o (lane_byte),
        .ld_data_o   (lane_ld)
    );

    // Request capture, second-access setup and registered result strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 1'b0; sext_q <= 1'b0; wb_q <= 1'b0; split_q <= 1'b0; fault_q <= 1'b0;
            size_q <= LDST_BYTE; rd_q <= '0; sd_q <= '0;
            eff_q <= '0; off_q <= '0; acc_addr_q <= '0; lo_byte_q <= '0;
            bus_start_q <= 1'b0; ld_wr_q <= 1'b0; ld_rd_q <= '0; ld_data_q <= '0;
            done_q <= 1'b0; fault_out_q <= 1'b0; wb_en_q <= 1'b0; wb_addr_q <= '0;
        end else begin
            bus_start_q <= 1'b0;
            ld_wr_q     <= 1'b0;
            done_q      <= 1'b0;
            fault_out_q <= 1'b0;
            wb_en_q     <= 1'b0;
            if (accept) begin
                load_q      <= load_i;
                size_q      <= size_i;
                sext_q      <= sign_extend_i;
                wb_q        <= writeback_i;
                rd_q        <= rd_i;
                sd_q        <= store_data_i;
                eff_q       <= eff;
                off_q       <= off_addr;
                split_q     <= split_req;
                fault_q     <= fault_req;
                acc_addr_q  <= eff;
                bus_start_q <= !fault_req;
            end
            if (acc_done && load_q) begin
                if (split_q && (state_q == ST_ACC0)) begin
                    lo_byte_q <= lane_byte;
                end else begin
                    ld_wr_q   <= 1'b1;
                    ld_rd_q   <= ((state_q == ST_ACC1) && !split_q) ? rd_q + 4'd1 : rd_q;
                    ld_data_q <= lane_ld;
                end
            end
            if (acc_done && (state_q == ST_ACC0) && need_two) begin
                acc_addr_q  <= (size_q == LDST_DUAL) ? eff_q + 32'd4 : eff_q + 32'd1;
                bus_start_q <= 1'b1;
            end
            if (state_q == ST_FIN) begin
                done_q      <= 1'b1;
                fault_out_q <= fault_q;
                wb_en_q     <= wb_q && !fault_q;
                wb_addr_q   <= off_q;
            end
        end
    end

    assign ready_o       = (state_q == ST_IDLE);
    assign bus_start_o   = bus_start_q;
    assign bus_write_o   = in_acc && !load_q;
    assign bus_addr_o    = in_acc ? acc_addr_q[31:2] : '0;
    assign bus_be_o      = in_acc ? lane_be : '0;
    assign bus_data_wr_o = (in_acc && !load_q) ? lane_st : '0;
    assign ld_wr_o       = ld_wr_q;
    assign ld_rd_o       = ld_rd_q;
    assign ld_data_o     = ld_data_q;
    assign wb_en_o       = wb_en_q;
    assign wb_addr_o     = wb_addr_q;
    assign done_o        = done_q;
    assign fault_o       = fault_out_q;

endmodule

// File: tb/tb_core_ldst_misc_fsm.sv
// Directed bench for core_ldst_misc_fsm with a scoreboard of expected bus
// accesses, register writes and completions.
module tb_core_ldst_misc_fsm;
    import core_ldst_misc_pkg::*;

    typedef struct { logic [29:0] addr; logic [3:0] be; logic wr; logic [31:0] data; } bus_exp_t;
    typedef struct { reg_num_t rd; logic [31:0] data; } ld_exp_t;
    typedef struct { logic fault; logic wb_en; logic [31:0] wb_addr; int lat; } done_exp_t;

    logic clk, rst_n, start, load, sext, inc, pre, wbk, bus_ready;
    ldst_size_e size_s;
    reg_num_t rd;
    logic [31:0] base, bus_data_rd;
    logic [11:0] offset;
    logic [63:0] sdata;
    logic ready_o, bus_start_o, bus_write_o, ld_wr_o, wb_en_o, done_o, fault_o;
    logic [29:0] bus_addr_o;
    logic [3:0] bus_be_o;
    logic [31:0] bus_data_wr_o, ld_data_o, wb_addr_o;
    reg_num_t ld_rd_o;

    bus_exp_t ebus[$];
    ld_exp_t eld[$];
    done_exp_t edone[$];
    logic [31:0] rdq[$];

    int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, n_bus_start = 0, bus_wait = 0, wcnt = 0, starts0 = 0;
    bit pend = 0, bus_mute = 0;
    bus_exp_t b_exp;
    logic [66:0] snap;
    ld_exp_t l_exp;
    done_exp_t d_exp;

    core_ldst_misc_fsm #(.OFF_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .ready_o(ready_o),
        .load_i(load), .size_i(size_s), .sign_extend_i(sext), .increment_i(inc),
        .pre_indexed_i(pre), .writeback_i(wbk), .rd_i(rd), .base_i(base),
        .offset_i(offset), .store_data_i(sdata),
        .bus_start_o(bus_start_o), .bus_write_o(bus_write_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_data_wr_o(bus_data_wr_o), .bus_ready_i(bus_ready),
        .bus_data_rd_i(bus_data_rd), .ld_wr_o(ld_wr_o), .ld_rd_o(ld_rd_o),
        .ld_data_o(ld_data_o), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o),
        .done_o(done_o), .fault_o(fault_o)
    );

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: register writes and completions against the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus_start_o) n_bus_start++;
            if (ld_wr_o) begin
                check("ld_wr_expected", 67'(eld.size() != 0), 67'd1);
                if (eld.size() != 0) begin
                    l_exp = eld.pop_front();
                    check("ld_rd", 67'(ld_rd_o), 67'(l_exp.rd));
                    check("ld_data", 67'(ld_data_o), 67'(l_exp.data));
                end
            end
            if (done_o) begin
                check("done_expected", 67'(edone.size() != 0), 67'd1);
                if (edone.size() != 0) begin
                    d_exp = edone.pop_front();
                    check("fault", 67'(fault_o), 67'(d_exp.fault));
                    check("wb_en", 67'(wb_en_o), 67'(d_exp.wb_en));
                    check("wb_addr", 67'(wb_addr_o), 67'(d_exp.wb_addr));
                    check("latency", 67'(cyc - acc_cyc), 67'(d_exp.lat));
                end
            end
        end
    end

    // Bus responder with programmable wait states; compares each access on its ready cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!bus_mute) begin
                bus_ready = 1'b0;
                if (bus_start_o) begin
                    pend = 1'b1;
                    wcnt = bus_wait;
                    snap = {bus_write_o, bus_addr_o, bus_be_o, bus_data_wr_o};
                end
                if (pend) begin
                    check("bus_hold", {bus_write_o, bus_addr_o, bus_be_o, bus_data_wr_o}, snap);
                    if (wcnt == 0) begin
                        pend = 1'b0;
                        bus_ready = 1'b1;
                        bus_data_rd = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
                        check("bus_expected", 67'(ebus.size() != 0), 67'd1);
                        if (ebus.size() != 0) begin
                            b_exp = ebus.pop_front();
                            check("bus_addr", 67'(bus_addr_o), 67'(b_exp.addr));
                            check("bus_be", 67'(bus_be_o), 67'(b_exp.be));
                            check("bus_write", 67'(bus_write_o), 67'(b_exp.wr));
                            if (b_exp.wr) check("bus_data_wr", 67'(bus_data_wr_o), 67'(b_exp.data));
                        end
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 67'(ready_o), 67'd1);
        check({tag, "_bus"}, 67'({bus_start_o, bus_write_o, bus_addr_o, bus_be_o}), 67'd0);
        check({tag, "_bus_wd"}, 67'(bus_data_wr_o), 67'd0);
        check({tag, "_ld"}, 67'({ld_wr_o, ld_rd_o, ld_data_o}), 67'd0);
        check({tag, "_res"}, 67'({wb_en_o, done_o, fault_o, wb_addr_o}), 67'd0);
    endtask

    task automatic issue(input logic ld, input ldst_size_e sz, input logic sx, input logic ic,
                         input logic pr, input logic wb, input reg_num_t r, input logic [31:0] b,
                         input logic [11:0] off, input logic [63:0] sd);
        int g = 0;
        while (!ready_o && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("ready_before_issue", 67'(ready_o), 67'd1);
        starts0 = n_bus_start;
        load = ld; size_s = sz; sext = sx; inc = ic; pre = pr; wbk = wb;
        rd = r; base = b; offset = off; sdata = sd;
        start = 1'b1;
        acc_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_busy", 67'(ready_o), 67'd0);
    endtask

    task automatic finish_op(input string tag, input int exp_starts);
        int g = 0;
        while ((edone.size() != 0 || !ready_o) && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check({tag, "_complete"}, 67'(edone.size() == 0 && eld.size() == 0 && ebus.size() == 0), 67'd1);
        @(posedge clk); #1;
        check({tag, "_bus_starts"}, 67'(n_bus_start - starts0), 67'(exp_starts));
    endtask

    initial begin
        int g;
        rst_n = 1'b0; start = 1'b0; load = 1'b0; size_s = LDST_BYTE; sext = 1'b0;
        inc = 1'b0; pre = 1'b0; wbk = 1'b0; rd = '0; base = '0; offset = '0; sdata = '0;
        bus_ready = 1'b0; bus_data_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LDRSB from lane 3
        ebus.push_back('{30'h400, 4'b1000, 1'b0, 32'h0});
        rdq.push_back(32'h80FF_FFFF);
        eld.push_back('{4'd1, 32'hFFFF_FF80});
        edone.push_back('{1'b0, 1'b0, 32'h1003, 3});
        issue(1, LDST_BYTE, 1, 1, 1, 0, 4'd1, 32'h1003, 12'h0, 64'h0);
        finish_op("ldrsb", 1);

        // STRH post-indexed with writeback
        ebus.push_back('{30'h800, 4'b0011, 1'b1, 32'h1234_1234});
        edone.push_back('{1'b0, 1'b1, 32'h2004, 3});
        issue(0, LDST_HALF, 0, 1, 0, 1, 4'd3, 32'h2000, 12'h4, 64'h1234);
        finish_op("strh", 1);

        // LDRD two words
        ebus.push_back('{30'hC00, 4'hF, 1'b0, 32'h0});
        ebus.push_back('{30'hC01, 4'hF, 1'b0, 32'h0});
        rdq.push_back(32'hA); rdq.push_back(32'hB);
        eld.push_back('{4'd2, 32'hA}); eld.push_back('{4'd3, 32'hB});
        edone.push_back('{1'b0, 1'b0, 32'h3000, 4});
        issue(1, LDST_DUAL, 0, 1, 1, 0, 4'd2, 32'h3000, 12'h0, 64'h0);
        finish_op("ldrd", 2);

        // LDRH at an odd address
`ifdef CORE_LDST_MISC_UNALIGNED_EN
        ebus.push_back('{30'h1000, 4'b0010, 1'b0, 32'h0});
        ebus.push_back('{30'h1000, 4'b0100, 1'b0, 32'h0});
        rdq.push_back(32'h0000_3400); rdq.push_back(32'h0012_0000);
        eld.push_back('{4'd1, 32'h1234});
        edone.push_back('{1'b0, 1'b1, 32'h4001, 4});
        issue(1, LDST_HALF, 0, 1, 1, 1, 4'd1, 32'h4001, 12'h0, 64'h0);
        finish_op("ldrh_odd", 2);
`else
        edone.push_back('{1'b1, 1'b0, 32'h4001, 2});
        issue(1, LDST_HALF, 0, 1, 1, 1, 4'd1, 32'h4001, 12'h0, 64'h0);
        finish_op("ldrh_odd", 0);
`endif

        // LDRSB, pre-indexed decrement, two wait states
        bus_wait = 2;
        ebus.push_back('{30'h13FF, 4'b0010, 1'b0, 32'h0});
        rdq.push_back(32'h0000_AB00);
        eld.push_back('{4'd7, 32'hFFFF_FFAB});
        edone.push_back('{1'b0, 1'b1, 32'h4FFD, 5});
        issue(1, LDST_BYTE, 1, 0, 1, 1, 4'd7, 32'h5000, 12'h3, 64'h0);
        finish_op("ldrsb_wait", 1);
        bus_wait = 0;

        // Misaligned word, odd-register dual: fault without bus traffic
        edone.push_back('{1'b1, 1'b0, 32'h6002, 2});
        issue(1, LDST_WORD, 0, 1, 1, 1, 4'd0, 32'h6002, 12'h0, 64'h0);
        finish_op("ldr_misaligned", 0);
        edone.push_back('{1'b1, 1'b0, 32'h6100, 2});
        issue(1, LDST_DUAL, 0, 1, 1, 0, 4'd5, 32'h6100, 12'h0, 64'h0);
        finish_op("ldrd_odd_rd", 0);

        // STRD pre-indexed with writeback
        ebus.push_back('{30'h1C02, 4'hF, 1'b1, 32'h1234_5678});
        ebus.push_back('{30'h1C03, 4'hF, 1'b1, 32'hCAFE_F00D});
        edone.push_back('{1'b0, 1'b1, 32'h7008, 4});
        issue(0, LDST_DUAL, 0, 1, 1, 1, 4'd4, 32'h7000, 12'h8, 64'hCAFE_F00D_1234_5678);
        finish_op("strd", 2);

        // LDRSH upper half
        ebus.push_back('{30'h2000, 4'b1100, 1'b0, 32'h0});
        rdq.push_back(32'h8001_7777);
        eld.push_back('{4'd9, 32'hFFFF_8001});
        edone.push_back('{1'b0, 1'b0, 32'h8002, 3});
        issue(1, LDST_HALF, 1, 0, 1, 0, 4'd9, 32'h8004, 12'h2, 64'h0);
        finish_op("ldrsh", 1);

        // LDRB zero-extended, post-indexed
        ebus.push_back('{30'h0, 4'b0010, 1'b0, 32'h0});
        rdq.push_back(32'h0000_F000);
        eld.push_back('{4'd10, 32'h0000_00F0});
        edone.push_back('{1'b0, 1'b0, 32'h11, 3});
        issue(1, LDST_BYTE, 0, 1, 0, 0, 4'd10, 32'h1, 12'h10, 64'h0);
        finish_op("ldrb", 1);

        // STRB lane 3
        ebus.push_back('{30'h2800, 4'b1000, 1'b1, 32'h5A5A_5A5A});
        edone.push_back('{1'b0, 1'b0, 32'hA003, 3});
        issue(0, LDST_BYTE, 0, 1, 1, 0, 4'd11, 32'hA003, 12'h0, 64'h5A);
        finish_op("strb", 1);

        // Reset during ACC1 of a dual load with a response pending
        ebus.push_back('{30'h2400, 4'hF, 1'b0, 32'h0});
        rdq.push_back(32'h11);
        eld.push_back('{4'd6, 32'h11});
        issue(1, LDST_DUAL, 0, 1, 1, 0, 4'd6, 32'h9000, 12'h0, 64'h0);
        g = 0;
        while (!ld_wr_o && g < 20) begin
            @(posedge clk); #1; g++;
        end
        check("rst_first_word", 67'(ld_wr_o), 67'd1);
        bus_mute = 1'b1;
        check("rst_acc1_start", 67'(bus_start_o), 67'd1);
        rst_n = 1'b0;
        bus_ready = 1'b1;
        bus_data_rd = 32'h22;
        #1;
        check_quiet("rst_async");
        @(posedge clk); #1;
        check_quiet("rst_mid");
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_late_ready", 67'({ld_wr_o, done_o, bus_start_o, ready_o}), 67'b0001);
        end
        bus_ready = 1'b0;
        bus_mute = 1'b0;
        check("rst_queues_empty", 67'(eld.size() == 0 && ebus.size() == 0 && edone.size() == 0), 67'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_ldst_misc_fsm.md
CORE_LDST_MISC_FSM -- requirements
Module: core_ldst_misc_fsm

Interface
REQ-001 SHALL have parameter OFF_W, default 12: offset operand width, zero-extended to 32 internally.
REQ-002 SHALL have port clk  in  1  sole clock.
REQ-003 SHALL have port rst_n  in  1  reset: asynchronous, active-low.
REQ-004 SHALL have ports start in 1 (request) and ready out 1 (idle, accepting); transfer occurs when start && ready.
REQ-005 SHALL have request ports: load in 1; size in ldst_size (BYTE/HALF/WORD/DUAL); sign_extend in 1; increment in 1; pre_indexed in 1; writeback in 1; rd in reg_num; base in 32; offset in OFF_W; store_data in 64 (low word = rd, high word = rd+1).
REQ-006 SHALL have bus ports: bus_start out 1; bus_write out 1; bus_addr out 30 (word address); bus_be out 4; bus_data_wr out 32; bus_ready in 1; bus_data_rd in 32.
REQ-007 SHALL have result ports: ld_wr out 1; ld_rd out reg_num; ld_data out 32; wb_en out 1; wb_addr out 32; done out 1; fault out 1.

Function
REQ-008 SHALL compute off_addr = increment ? base+offset : base-offset (mod 2^32); eff = pre_indexed ? off_addr : base.
REQ-009 SHALL latch all request fields on the accepting edge; ready SHALL be low in all states except IDLE; start while busy is ignored.
REQ-010 SHALL implement states IDLE, ACC0, ACC1, FIN; IDLE->ACC0 on accept; ACC0->ACC1 when a second access is needed, else ->FIN; ACC1->FIN; FIN->IDLE unconditionally.
REQ-011 SHALL pulse bus_start for exactly one cycle on entry to ACC0/ACC1, hold bus_addr/bus_be/bus_write/bus_data_wr stable until bus_ready, and leave the state on the bus_ready cycle.
REQ-012 SHALL set bus_be: BYTE = 1<<eff[1:0]; aligned HALF = 3<<eff[1:0]; WORD/DUAL = 4'hF; store data SHALL be replicated across lanes.
REQ-013 SHALL fault (no bus access, direct IDLE->FIN) for WORD/DUAL with eff[1:0]!=0, DUAL with odd rd, or misaligned HALF when the Configuration feature is absent.
REQ-014 SHALL, for DUAL, access eff then eff+4; loads pulse ld_wr with ld_rd=rd after ACC0 and ld_rd=rd+1 after ACC1.
REQ-015 SHALL, for BYTE/HALF loads, extract the lane, zero-extend, or sign-extend from bit 7/15 when sign_extend, and pulse ld_wr one cycle after bus_ready.
REQ-016 SHALL, in FIN, pulse done for one cycle; fault = 1 only for faulted ops; wb_en = writeback && !fault; wb_addr = off_addr.
REQ-017 SHALL give a best-case latency of accept -> done = 3 cycles for single access with zero-wait bus_ready.
REQ-018 SHALL ignore bus_ready outside ACC0/ACC1.

Reset
REQ-019 SHALL on rst_n low force IDLE and drive ready=1 and every other output 0 (bus_addr, bus_be, ld_data, wb_addr included), including mid-transaction; a pending bus response is discarded.

Configuration
REQ-020 SHALL, with CORE_LDST_MISC_UNALIGNED_EN defined, split HALF with eff[0]=1 into byte accesses at eff (ACC0) and eff+1 (ACC1), assembling little-endian before extension; without it, such ops fault per REQ-013.

Structure
REQ-021 SHALL place ldst_size (with added LDST_WORD, LDST_DUAL) and the FSM state enum in the shared core uarch package.
REQ-022 SHALL use one combinational sub-module core_ldst_misc_lanes (byte enables, store replication, load extraction/extension).

Verification
REQ-023 LDRSB base=0x1003, offset=0, pre, bus_data_rd=0x80FFFFFF -> bus_be=4'b1000, ld_data=0xFFFFFF80, done 3 cycles after accept.
REQ-024 STRH post-indexed, base=0x2000, offset=4, increment, writeback, store 0x1234 -> bus_be=4'b0011, bus_data_wr=0x12341234, wb_addr=0x2004.
REQ-025 LDRD rd=2, base=0x3000, reads 0xA, 0xB -> ld_wr pulses rd=2 data 0xA, then rd=3 data 0xB; bus addresses 0xC00, 0xC01.
REQ-026 LDRH eff=0x4001: with macro -> two byte accesses, bytes 0x34, 0x12 -> ld_data=0x1234; without -> fault=1, no bus_start, wb_en=0.
REQ-027 rst_n low during ACC1 of DUAL with bus_ready pending -> outputs 0, ready=1 next cycle, late bus_ready produces no ld_wr.
